// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and constants for the round-robin RAM arbiter.
// Imported by the interface, the pick sub-module and the top.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TB    = 2'd2
   } arb_state_t;

   localparam int DEF_TIMEOUT = 64;

   // Index width for n items; never 0 so a one-entry index still has a bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle around the arbiter: channel side, testbench override and RAM port.
// The arbiter uses the slave modport; its environment uses master.
interface mem_arbiter_rr_if
   import mem_arb_pkg::*;
#(
   parameter int NCH = 2,
   parameter int AW  = 32,
   parameter int DW  = 32
);
   logic [NCH-1:0]          req_ren;
   logic [NCH-1:0]          req_wen;
   logic [NCH*AW-1:0]       req_addr;
   logic [NCH*DW-1:0]       req_store;
   logic [NCH-1:0]          req_ready;
   logic [NCH-1:0]          req_err;
   logic [DW-1:0]           req_load;

   logic                    tb_ctrl;
   logic                    tb_ren;
   logic                    tb_wen;
   logic [AW-1:0]           tb_addr;
   logic [DW-1:0]           tb_store;

   logic                    ram_ren;
   logic                    ram_wen;
   logic [AW-1:0]           ram_addr;
   logic [DW-1:0]           ram_store;
   logic [DW-1:0]           ram_load;
   logic                    ram_ready;

   logic [idx_w(NCH)-1:0]   grant_id;
   logic                    busy;

   modport slave (
      input  req_ren, req_wen, req_addr, req_store,
      input  tb_ctrl, tb_ren, tb_wen, tb_addr, tb_store,
      input  ram_load, ram_ready,
      output req_ready, req_err, req_load,
      output ram_ren, ram_wen, ram_addr, ram_store,
      output grant_id, busy
   );

   modport master (
      output req_ren, req_wen, req_addr, req_store,
      output tb_ctrl, tb_ren, tb_wen, tb_addr, tb_store,
      output ram_load, ram_ready,
      input  req_ready, req_err, req_load,
      input  ram_ren, ram_wen, ram_addr, ram_store,
      input  grant_id, busy
   );

endinterface

// File: rtl/mem_arbiter_rr_rr_pick.sv
// Combinational round-robin pick: first requester after i_last, wrapping mod NCH.
// Uses a doubled request vector so the wrap needs no modulo in the scan.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int NCH = 2
) (
   input  logic [NCH-1:0]          i_req,
   input  logic [idx_w(NCH)-1:0]   i_last,
   output logic [idx_w(NCH)-1:0]   o_win,
   output logic                    o_valid
);
   localparam int IW = idx_w(NCH);

   logic [2*NCH-1:0] w_dbl;

   assign w_dbl = {i_req, i_req};

   // The window (i_last, i_last+NCH] sees every channel once, starting just
   // after the last grant; scanning downward leaves the lowest hit in o_win.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      o_win   = '0;
      o_valid = 1'b0;
      for (int j = 2*NCH-1; j >= 0; j--) begin
         if (w_dbl[j] && (j > int'(i_last)) && (j <= int'(i_last) + NCH)) begin
            o_valid = 1'b1;
            o_win   = IW'(j % NCH);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel round-robin arbiter for a single RAM port, with a testbench
// override path and a per-transaction timeout.
module mem_arbiter_rr
   import mem_arb_pkg::*;
#(
   parameter int NCH     = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic               CLK,
   input logic               nRST,
   mem_arbiter_rr_if.slave   io_bus
);
   localparam int IW = idx_w(NCH);
   localparam int CW = idx_w(TIMEOUT);

   arb_state_t      r_state;
   arb_state_t      w_next_state;
   logic [IW-1:0]   r_grant_id;
   logic [IW-1:0]   r_last_grant;
   logic [CW-1:0]   r_cnt;

   logic [NCH-1:0]  w_req;
   logic [IW-1:0]   w_win;
   logic            w_valid;
   logic            w_take;
   logic            w_done;

   assign w_req = io_bus.req_ren | io_bus.req_wen;

   rr_pick #(.NCH(NCH)) u_pick (
      .i_req   (w_req),
      .i_last  (r_last_grant),
      .o_win   (w_win),
      .o_valid (w_valid)
   );

   // NOTE: state is reset asynchronously, so the combinational ram strobes
   // drop the moment nRST goes low, without waiting for a clock.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_last_grant <= IW'(NCH-1);
         r_grant_id   <= '0;
         r_cnt        <= '0;
      end else begin
         if (w_take) begin
            r_grant_id <= w_win;
            r_cnt      <= '0;
         end else if (r_state == GRANT) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_done) begin
            r_last_grant <= r_grant_id;
         end
      end
   end

   always_comb begin
      w_next_state     = r_state;
      w_take           = 1'b0;
      w_done           = 1'b0;
      io_bus.req_ready = '0;
      io_bus.req_err   = '0;
      io_bus.ram_ren   = 1'b0;
      io_bus.ram_wen   = 1'b0;
      io_bus.ram_addr  = '0;
      io_bus.ram_store = '0;
      case (r_state)
         IDLE: begin
            if (io_bus.tb_ctrl) begin
               w_next_state = TB;
            end else if (w_valid) begin
               w_take       = 1'b1;
               w_next_state = GRANT;
            end
         end
         GRANT: begin
            // Write wins when a channel raises both strobes.
            io_bus.ram_wen   = io_bus.req_wen[r_grant_id];
            io_bus.ram_ren   = io_bus.req_ren[r_grant_id] & ~io_bus.req_wen[r_grant_id];
            io_bus.ram_addr  = io_bus.req_addr[int'(r_grant_id)*AW +: AW];
            io_bus.ram_store = io_bus.req_store[int'(r_grant_id)*DW +: DW];
            if (io_bus.ram_ready) begin
               io_bus.req_ready[r_grant_id] = 1'b1;
               w_done       = 1'b1;
               w_next_state = IDLE;
            end else if (!w_req[r_grant_id]) begin
               w_next_state = IDLE;
            end else if (r_cnt == CW'(TIMEOUT-1)) begin
               io_bus.req_err[r_grant_id] = 1'b1;
               w_done       = 1'b1;
               w_next_state = IDLE;
            end
         end
         TB: begin
            io_bus.ram_ren   = io_bus.tb_ren;
            io_bus.ram_wen   = io_bus.tb_wen;
            io_bus.ram_addr  = io_bus.tb_addr;
            io_bus.ram_store = io_bus.tb_store;
            if (!io_bus.tb_ctrl) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   assign io_bus.req_load = io_bus.ram_load;
   assign io_bus.grant_id = r_grant_id;
   assign io_bus.busy     = (r_state != IDLE);

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-channel RAM access arbiter with round-robin fairness.
- Includes a testbench-override path and a per-transaction timeout.
- Sits between the processor side (cores/caches) and the single ram port, alongside the system top.
- Generalises single-master ram mux to NCH masters, with arbitration state, fairness guarantee and error recovery.

Parameters:
NCH, 2, number of requesting channels (>=2)
AW, 32, address width
DW, 32, data width
TIMEOUT, 64, max cycles waiting for ram_ready before abort (>=2)

Ports:
CLK  in  1  clock
nRST  in  1  reset; asynchronous, active-low; clock CLK
req_ren  in  NCH  per-channel read request
req_wen  in  NCH  per-channel write request
req_addr  in  NCH*AW  per-channel address, channel i at [i*AW +: AW]
req_store  in  NCH*DW  per-channel write data
req_ready  out  NCH  per-channel access-complete strobe
req_err  out  NCH  per-channel timeout strobe
req_load  out  DW  read data, broadcast to all channels
tb_ctrl  in  1  testbench takes ram
tb_ren  in  1  testbench read
tb_wen  in  1  testbench write
tb_addr  in  AW  testbench address
tb_store  in  DW  testbench write data
ram_ren  out  1  to ram
ram_wen  out  1  to ram
ram_addr  out  AW  to ram
ram_store  out  DW  to ram
ram_load  in  DW  from ram
ram_ready  in  1  ram access complete this cycle
grant_id  out  $clog2(NCH)  currently granted channel (valid in GRANT)
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, GRANT, TB.
- Reset values:
  - state=IDLE; last_grant=NCH-1, so channel 0 wins first; grant_id=0; timeout count=0.
  - All outputs 0; ram_ren/ram_wen deassert asynchronously on nRST low.
- A channel is requesting when req_ren[i] or req_wen[i] is set.
  - Both set: write wins, ram_ren=0.
- IDLE:
  - tb_ctrl=1 -> TB. tb_ctrl has priority over pending requests.
  - Otherwise, if any channel is requesting: pick the first requester scanning last_grant+1, last_grant+2 ... mod NCH. Register it as grant_id, clear the counter, go to GRANT.
  - ram_ren=ram_wen=0 in IDLE.
- GRANT:
  - ram_* outputs mirror channel grant_id combinationally.
  - req_ready[grant_id]=ram_ready; all other req_ready bits are 0.
  - ram_ready=1 -> last_grant=grant_id, go to IDLE. This gives a one-cycle bubble between grants.
  - Granted channel drops both ren and wen before ready -> abort to IDLE. last_grant is unchanged and no strobe is issued.
  - Counter reaches TIMEOUT-1 without ram_ready -> req_err[grant_id]=1 for one cycle, last_grant=grant_id, go to IDLE.
  - ram_ready on that same cycle has precedence: completion, no error.
  - tb_ctrl rising during GRANT is ignored until the current transaction ends. It is then taken from IDLE on the next cycle.
- TB:
  - ram_* mirror the tb_* inputs combinationally.
  - All req_ready and req_err bits are 0.
  - tb_ctrl=0 -> IDLE.
- req_load=ram_load at all times.
- Latency: a request first seen in IDLE at cycle t drives ram at t+1. req_ready is asserted in the same cycle as ram_ready.
- Fairness: a continuously asserted request is granted after at most NCH-1 other grants.
- Reset mid-GRANT: the transaction is dropped with no strobe. It restarts from channel 0 priority.
- Address/data are passed unmodified. No width conversion.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, GRANT, TB};
  - the grant index width function;
  - the default TIMEOUT constant.
- Sub-module rr_pick (parameter NCH): combinational round-robin pick.
  - Inputs: request vector and last_grant.
  - Outputs: winner index and a valid bit.
  - Implemented as a double-width masked priority encoder. Unit-tested separately.

Test Plan:
- Reset, then ch0 read of addr 0x100 held; ram_ready asserted 3 cycles later -> ram_addr=0x100 from cycle 1, req_ready[0] pulses once, then IDLE.
- NCH=4, all channels requesting continuously, ram_ready every 2nd cycle -> grant order 0,1,2,3,0,1; no channel granted twice before the others.
- Ch1 asserts ren and wen together with store=0xDEADBEEF -> ram_wen=1, ram_ren=0, ram_store=0xDEADBEEF.
- TIMEOUT=8, ram_ready held 0 -> req_err[grant_id] pulses on the 8th GRANT cycle; next grant goes to the next requester.
- tb_ctrl raised mid-GRANT -> the current access completes, then TB. ram_addr follows tb_addr=0x40, and req_ready stays 0 until tb_ctrl drops.
- nRST pulsed low during GRANT -> ram_ren/ram_wen go 0 immediately; after release, ch0 wins even if ch1 had the last grant.
